// File: rtl/hs_receiver.sv
// hs_receiver: receiving side of a 4-phase level handshake.
// Captures DATA_IN when a synchronized request arrives, offers it to a
// downstream consumer, and acknowledges the sender once it is accepted.
// A request withdrawn before acceptance raises a sticky protocol error.
module hs_receiver #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_SYNC,
    input  logic [BUS_WIDTH-1:0] DATA_IN,
    input  logic                 RDY_IN,
    output logic [BUS_WIDTH-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 ACK,
    output logic [CNT_WIDTH-1:0] XFER_CNT,
    output logic                 PROTO_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VALID = 2'b01,
        ACKED = 2'b10
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [BUS_WIDTH-1:0]   data_out_r;
    logic [BUS_WIDTH-1:0]   data_out_s;
    logic                   data_valid_r;
    logic                   data_valid_s;
    logic                   ack_r;
    logic                   ack_s;
    logic [CNT_WIDTH-1:0]   xfer_cnt_r;
    logic [CNT_WIDTH-1:0]   xfer_cnt_s;
    logic                   proto_err_r;
    logic                   proto_err_s;

    // Next-state and next-output decode of the handshake FSM.
    always_comb begin
        state_s      = state_r;
        data_out_s   = data_out_r;
        data_valid_s = data_valid_r;
        ack_s        = ack_r;
        xfer_cnt_s   = xfer_cnt_r;
        proto_err_s  = proto_err_r;
        case (state_r)
            IDLE: begin
                if (REQ_SYNC) begin
                    data_out_s   = DATA_IN;
                    data_valid_s = 1'b1;
                    state_s      = VALID;
                end else begin
                    state_s = IDLE;
                end
            end
            VALID: begin
                // Withdrawal wins over a simultaneous consumer accept.
                if (!REQ_SYNC) begin
                    proto_err_s  = 1'b1;
                    data_valid_s = 1'b0;
                    ack_s        = 1'b0;
                    state_s      = IDLE;
                end else if (RDY_IN) begin
                    data_valid_s = 1'b0;
                    ack_s        = 1'b1;
                    xfer_cnt_s   = xfer_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_s      = ACKED;
                end else begin
                    data_valid_s = 1'b1;
                    ack_s        = 1'b0;
                    state_s      = VALID;
                end
            end
            ACKED: begin
                if (REQ_SYNC) begin
                    ack_s   = 1'b1;
                    state_s = ACKED;
                end else begin
                    ack_s   = 1'b0;
                    state_s = IDLE;
                end
            end
            default: begin
                // Recover from an illegal encoding without offering data.
                state_s      = IDLE;
                data_valid_s = 1'b0;
                ack_s        = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r      <= IDLE;
            data_out_r   <= {BUS_WIDTH{1'b0}};
            data_valid_r <= 1'b0;
            ack_r        <= 1'b0;
            xfer_cnt_r   <= {CNT_WIDTH{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            data_out_r   <= data_out_s;
            data_valid_r <= data_valid_s;
            ack_r        <= ack_s;
            xfer_cnt_r   <= xfer_cnt_s;
            proto_err_r  <= proto_err_s;
        end
    end

    assign DATA_OUT   = data_out_r;
    assign DATA_VALID = data_valid_r;
    assign ACK        = ack_r;
    assign XFER_CNT   = xfer_cnt_r;
    assign PROTO_ERR  = proto_err_r;

endmodule

// File: tb/tb_hs_receiver.sv
// Self-checking bench for hs_receiver: directed handshake scenarios followed
// by randomized request/ready traffic, all compared against a transaction
// level reference model.
module tb_hs_receiver;

    logic       CLK;
    logic       RST;
    logic       REQ_SYNC;
    logic [7:0] DATA_IN;
    logic       RDY_IN;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID;
    logic       ACK;
    logic [7:0] XFER_CNT;
    logic       PROTO_ERR;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: a word is either absent, pending for the consumer,
    // or delivered and being acknowledged until the sender drops its request.
    bit         m_pending;
    bit         m_ack;
    bit         m_err;
    logic [7:0] m_word;
    int         m_xfers;

    hs_receiver #(.BUS_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_SYNC  (REQ_SYNC),
        .DATA_IN   (DATA_IN),
        .RDY_IN    (RDY_IN),
        .DATA_OUT  (DATA_OUT),
        .DATA_VALID(DATA_VALID),
        .ACK       (ACK),
        .XFER_CNT  (XFER_CNT),
        .PROTO_ERR (PROTO_ERR)
    );

    // 100 MHz receiving clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pending = 1'b0;
        m_ack     = 1'b0;
        m_err     = 1'b0;
        m_word    = 8'h00;
        m_xfers   = 0;
    endtask

    // Apply the handshake rules for one clock edge using the sampled inputs.
    task automatic model_edge(input bit req, input bit rdy, input logic [7:0] din);
        if (m_ack) begin
            m_ack = req;
        end else if (m_pending) begin
            if (!req) begin
                m_err     = 1'b1;
                m_pending = 1'b0;
            end else if (rdy) begin
                m_pending = 1'b0;
                m_ack     = 1'b1;
                m_xfers   = m_xfers + 1;
            end
        end else if (req) begin
            m_word    = din;
            m_pending = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data_out"},   {24'd0, DATA_OUT},  {24'd0, m_word});
        check({tag, ".data_valid"}, {31'd0, DATA_VALID}, {31'd0, m_pending});
        check({tag, ".ack"},        {31'd0, ACK},        {31'd0, m_ack});
        check({tag, ".xfer_cnt"},   {24'd0, XFER_CNT},   m_xfers % 256);
        check({tag, ".proto_err"},  {31'd0, PROTO_ERR},  {31'd0, m_err});
    endtask

    // One clock: model follows the inputs present at the edge, then outputs are checked.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge(REQ_SYNC, RDY_IN, DATA_IN);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        #1;
        RST = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        RST      = 1'b0;
        REQ_SYNC = 1'b0;
        DATA_IN  = 8'h00;
        RDY_IN   = 1'b0;
        model_reset();
        #3;
        check_all("reset_state");
        @(negedge CLK);
        RST = 1'b1;

        // Basic transfer.
        RDY_IN = 1'b1; DATA_IN = 8'hA5; REQ_SYNC = 1'b1;
        step("basic_capture");
        check("basic_dout_const", {24'd0, DATA_OUT}, 32'h0000_00A5);
        step("basic_ack");
        check("basic_cnt_const", {24'd0, XFER_CNT}, 32'd1);
        step("basic_ack_hold");
        REQ_SYNC = 1'b0;
        step("basic_ack_fall");
        step("basic_idle");

        // Backpressure with DATA_IN changing while stalled.
        RDY_IN = 1'b0; DATA_IN = 8'hA5; REQ_SYNC = 1'b1;
        step("bp_capture");
        DATA_IN = 8'h3C;
        for (int i = 0; i < 10; i++) step("bp_stall");
        check("bp_dout_const", {24'd0, DATA_OUT}, 32'h0000_00A5);
        RDY_IN = 1'b1;
        step("bp_accept");
        REQ_SYNC = 1'b0;
        step("bp_release");

        // Withdrawal with and without a simultaneous ready.
        RDY_IN = 1'b0; DATA_IN = 8'h11; REQ_SYNC = 1'b1;
        step("wd_capture");
        REQ_SYNC = 1'b0;
        step("wd_drop");
        RDY_IN = 1'b0; DATA_IN = 8'h22; REQ_SYNC = 1'b1;
        step("wd2_capture");
        REQ_SYNC = 1'b0; RDY_IN = 1'b1;
        step("wd2_drop_rdy");
        check("wd_err_const", {31'd0, PROTO_ERR}, 32'd1);
        DATA_IN = 8'h33; REQ_SYNC = 1'b1;
        step("wd_clean_capture");
        step("wd_clean_ack");
        REQ_SYNC = 1'b0;
        step("wd_clean_release");

        // Counter wrap from a fresh reset.
        do_reset();
        RDY_IN = 1'b1;
        for (int i = 0; i < 256; i++) begin
            DATA_IN = i[7:0]; REQ_SYNC = 1'b1;
            step("wrap_capture");
            step("wrap_ack");
            REQ_SYNC = 1'b0;
            step("wrap_release");
        end
        check("wrap_cnt_zero", {24'd0, XFER_CNT}, 32'd0);
        check("wrap_last_word", {24'd0, DATA_OUT}, 32'h0000_00FF);

        // Reset while acknowledged, request held through release.
        DATA_IN = 8'h5A; REQ_SYNC = 1'b1; RDY_IN = 1'b1;
        step("rst_capture");
        step("rst_acked");
        do_reset();
        DATA_IN = 8'h6B;
        step("rst_recapture");
        check("rst_recapture_valid", {31'd0, DATA_VALID}, 32'd1);
        step("rst_ack");
        REQ_SYNC = 1'b0;
        step("rst_release");

        // Re-request on the cycle right after ACK falls.
        DATA_IN = 8'h7E; REQ_SYNC = 1'b1;
        step("rr_ack_fall");
        check("rr_capture_valid", {31'd0, DATA_VALID}, 32'd1);
        check("rr_capture_data", {24'd0, DATA_OUT}, 32'h0000_007E);
        step("rr_ack");
        check("rr_cnt_const", {24'd0, XFER_CNT}, 32'd2);
        REQ_SYNC = 1'b0;
        step("rr_release");
        DATA_IN = 8'h81; REQ_SYNC = 1'b1;
        step("rr2_capture");

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            REQ_SYNC = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            RDY_IN   = $urandom_range(0, 1) == 1;
            DATA_IN  = 8'($urandom);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
